// File: rtl/alu_mdu.sv
// Multi-cycle ALU with signed multiply and an optional radix-2 restoring divider.
// Define ALU_MDU_DIV_EN to build the divider; otherwise DIV/DIVU return zeros in one cycle.
module alu_mdu #(
    parameter int WIDTH = 32,
    parameter int SA_W  = 5
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] num1,
    input  logic [WIDTH-1:0] num2,
    input  logic [SA_W-1:0]  sa,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic             overflow,
    output logic             zero,
    output logic             divzero
);

    localparam logic [3:0] OP_ADD  = 4'd0,  OP_ADDU = 4'd1,  OP_SUB  = 4'd2,  OP_SUBU = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4,  OP_OR   = 4'd5,  OP_XOR  = 4'd6,  OP_NOR  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8,  OP_SLTU = 4'd9,  OP_SLL  = 4'd10, OP_SRL  = 4'd11;
    localparam logic [3:0] OP_SRA  = 4'd12, OP_MULT = 4'd13, OP_DIV  = 4'd14, OP_DIVU = 4'd15;
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, state_nxt;

    logic accept, is_div;
    logic signed [WIDTH-1:0] s1, s2;
    logic [WIDTH-1:0]   sum, dif, alu_lo, alu_hi;
    logic [2*WIDTH-1:0] prod;
    logic               alu_ovf;

    // Signed overflow of a two's-complement add, from the operand and result sign bits.
    function automatic logic add_ovf(input logic sign_a, input logic sign_b, input logic sign_r);
        return (sign_a == sign_b) && (sign_r != sign_a);
    endfunction

    assign accept    = in_valid && (state == IDLE);
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    assign s1   = num1;
    assign s2   = num2;
    assign sum  = num1 + num2;
    assign dif  = num1 + ~num2 + ONE;
    assign prod = {{WIDTH{num1[WIDTH-1]}}, num1} * {{WIDTH{num2[WIDTH-1]}}, num2};

    always_comb begin
        alu_lo  = '0;
        alu_hi  = '0;
        alu_ovf = 1'b0;
        case (op)
            OP_ADD:  begin alu_lo = sum; alu_ovf = add_ovf(num1[WIDTH-1], num2[WIDTH-1], sum[WIDTH-1]); end
            OP_ADDU: alu_lo = sum;
            OP_SUB:  begin alu_lo = dif; alu_ovf = add_ovf(num1[WIDTH-1], ~num2[WIDTH-1], dif[WIDTH-1]); end
            OP_SUBU: alu_lo = dif;
            OP_AND:  alu_lo = num1 & num2;
            OP_OR:   alu_lo = num1 | num2;
            OP_XOR:  alu_lo = num1 ^ num2;
            OP_NOR:  alu_lo = ~(num1 | num2);
            OP_SLT:  alu_lo = {{(WIDTH-1){1'b0}}, (s1 < s2)};
            OP_SLTU: alu_lo = {{(WIDTH-1){1'b0}}, (num1 < num2)};
            OP_SLL:  alu_lo = num2 << sa;
            OP_SRL:  alu_lo = num2 >> sa;
            OP_SRA:  alu_lo = s2 >>> sa;
            OP_MULT: {alu_hi, alu_lo} = prod;
            default: ;
        endcase
    end

`ifdef ALU_MDU_DIV_EN
    logic [SA_W-1:0]  cnt;
    logic [WIDTH-1:0] rem, quo, dvs, n1, mag1, mag2;
    logic [WIDTH-1:0] rem_nxt, quo_nxt, q_fin, r_fin;
    logic [WIDTH:0]   shifted, trial;
    logic             neg_q, neg_r, dz, last, signed_div;

    assign is_div     = (op == OP_DIV) || (op == OP_DIVU);
    assign signed_div = (op == OP_DIV);
    assign mag1       = (signed_div && num1[WIDTH-1]) ? ~num1 + ONE : num1;
    assign mag2       = (signed_div && num2[WIDTH-1]) ? ~num2 + ONE : num2;

    // One restoring step: shift in the next dividend bit, keep the trial difference if it fits.
    assign shifted = {rem, quo[WIDTH-1]};
    assign trial   = shifted - {1'b0, dvs};
    assign rem_nxt = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    assign quo_nxt = {quo[WIDTH-2:0], ~trial[WIDTH]};
    assign last    = (cnt == SA_W'(WIDTH - 1));
    assign q_fin   = dz ? '1 : (neg_q ? ~quo_nxt + ONE : quo_nxt);
    assign r_fin   = dz ? n1 : (neg_r ? ~rem_nxt + ONE : rem_nxt);

    always_ff @(posedge clk) begin
        if (accept) begin
            cnt   <= '0;
            rem   <= '0;
            quo   <= mag1;
            dvs   <= mag2;
            n1    <= num1;
            dz    <= (num2 == '0);
            neg_q <= signed_div && (num1[WIDTH-1] ^ num2[WIDTH-1]);
            neg_r <= signed_div && num1[WIDTH-1];
        end else if (state == CALC) begin
            cnt <= cnt + SA_W'(1);
            rem <= rem_nxt;
            quo <= quo_nxt;
        end
    end
`else
    assign is_div = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid) state_nxt = is_div ? CALC : DONE;
`ifdef ALU_MDU_DIV_EN
            CALC: if (last) state_nxt = DONE;
`else
            CALC: state_nxt = IDLE;
`endif
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

`ifdef ALU_MDU_DIV_EN
    logic dz_q;
    assign divzero = dz_q;
`else
    assign divzero = 1'b0;
`endif

    // Result registers: written once per operation and held through DONE.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            result   <= '0;
            hi       <= '0;
            overflow <= 1'b0;
            zero     <= 1'b0;
`ifdef ALU_MDU_DIV_EN
            dz_q     <= 1'b0;
`endif
        end else if (accept && !is_div) begin
            result   <= alu_lo;
            hi       <= alu_hi;
            overflow <= alu_ovf;
            zero     <= (alu_lo == '0);
`ifdef ALU_MDU_DIV_EN
            dz_q     <= 1'b0;
        end else if (state == CALC && last) begin
            result   <= q_fin;
            hi       <= r_fin;
            overflow <= 1'b0;
            zero     <= (q_fin == '0);
            dz_q     <= dz;
`endif
        end
    end

endmodule

// File: tb/tb_alu_mdu.sv
// Randomized bench for alu_mdu with a transaction-level reference model.
module tb_alu_mdu;

    logic        clk, resetn, in_valid, in_ready, out_valid, out_ready;
    logic [3:0]  op;
    logic [31:0] num1, num2, result, hi;
    logic [4:0]  sa;
    logic        overflow, zero, divzero;

    int n_vec = 0;
    int n_err = 0;

    alu_mdu #(.WIDTH(32), .SA_W(5)) dut (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .num1(num1), .num2(num2), .sa(sa),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .hi(hi), .overflow(overflow), .zero(zero), .divzero(divzero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] r;
        logic [31:0] h;
        logic        ovf;
        logic        z;
        logic        dz;
        int          lat;
    } exp_t;

    // Expected outcome of one operation, from plain integer arithmetic.
    function automatic exp_t model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                                   input logic [4:0] s);
        exp_t   e;
        int     ia, ib;
        longint la, lb, t;
        e.r = '0; e.h = '0; e.ovf = 1'b0; e.dz = 1'b0; e.lat = 1;
        ia = a; ib = b; la = ia; lb = ib;
        case (o)
            4'd0:  begin e.r = a + b; t = la + lb; e.ovf = (t != longint'(int'(e.r))); end
            4'd1:  e.r = a + b;
            4'd2:  begin e.r = a - b; t = la - lb; e.ovf = (t != longint'(int'(e.r))); end
            4'd3:  e.r = a - b;
            4'd4:  e.r = a & b;
            4'd5:  e.r = a | b;
            4'd6:  e.r = a ^ b;
            4'd7:  e.r = ~(a | b);
            4'd8:  e.r = (ia < ib) ? 32'd1 : 32'd0;
            4'd9:  e.r = (a < b) ? 32'd1 : 32'd0;
            4'd10: e.r = b << s;
            4'd11: e.r = b >> s;
            4'd12: e.r = ib >>> s;
            4'd13: begin t = la * lb; {e.h, e.r} = t; end
`ifdef ALU_MDU_DIV_EN
            4'd14: begin
                e.lat = 33;
                if (b == 0) begin e.r = '1; e.h = a; e.dz = 1'b1; end
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin e.r = a; e.h = '0; end
                else begin e.r = ia / ib; e.h = ia % ib; end
            end
            4'd15: begin
                e.lat = 33;
                if (b == 0) begin e.r = '1; e.h = a; e.dz = 1'b1; end
                else begin e.r = a / b; e.h = a % b; end
            end
`endif
            default: ;
        endcase
        e.z = (e.r == 0);
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Transaction tracker: which operation is in flight and how long since it was accepted.
    exp_t cur;
    bit   busy = 1'b0;
    int   cyc  = 0;

    always @(posedge clk) begin
        if (!resetn) begin
            busy = 1'b0;
        end else if (busy) begin
            if (cyc >= cur.lat && out_ready) busy = 1'b0;
            else cyc++;
        end else if (in_valid) begin
            cur  = model(op, num1, num2, sa);
            busy = 1'b1;
            cyc  = 1;
        end
    end

    always @(negedge clk) begin
        if (!resetn) begin
            chk("reset out_valid", 32'(out_valid), 32'd0);
            chk("reset result", result, 32'd0);
            chk("reset hi", hi, 32'd0);
            chk("reset flags", {29'd0, overflow, zero, divzero}, 32'd0);
        end else begin
            chk("in_ready", 32'(in_ready), 32'(!busy));
            chk("out_valid", 32'(out_valid), 32'(busy && cyc >= cur.lat));
            if (out_valid && busy && cyc >= cur.lat) begin
                chk("result", result, cur.r);
                chk("hi", hi, cur.h);
                chk("overflow", 32'(overflow), 32'(cur.ovf));
                chk("zero", 32'(zero), 32'(cur.z));
                chk("divzero", 32'(divzero), 32'(cur.dz));
            end
        end
    end

    logic [31:0] last_r, last_h;
    logic        last_ovf, last_dz;

    task automatic do_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] s, input int hold, output int lat);
        int guard;
        @(negedge clk);
        guard = 0;
        while (!in_ready && guard < 100) begin @(negedge clk); guard++; end
        in_valid = 1'b1; op = o; num1 = a; num2 = b; sa = s; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'($urandom); op = 4'($urandom); num1 = $urandom; num2 = $urandom; sa = 5'($urandom);
        lat = 1;
        while (!out_valid && lat < 100) begin @(negedge clk); lat++; end
        if (!out_valid) begin
            n_vec++; n_err++;
            $display("FAIL timeout op %0d: out_valid 0 after %0d cycles, required 1", o, lat);
        end
        last_r = result; last_h = hi; last_ovf = overflow; last_dz = divzero;
        repeat (hold) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b0;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat;
        exp_t m;
        resetn = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = '0; num1 = '0; num2 = '0; sa = '0;

        // Model pinned against hand-computed values.
        m = model(4'd0, 32'h7FFF_FFFF, 32'd1, 5'd0);
        chk("model ADD result", m.r, 32'h8000_0000);
        chk("model ADD ovf", 32'(m.ovf), 32'd1);
        m = model(4'd1, 32'h7FFF_FFFF, 32'd1, 5'd0);
        chk("model ADDU ovf", 32'(m.ovf), 32'd0);
        m = model(4'd12, 32'd0, 32'h8000_0000, 5'd4);
        chk("model SRA", m.r, 32'hF800_0000);
        m = model(4'd13, 32'hFFFF_FFFF, 32'd2, 5'd0);
        chk("model MULT hi", m.h, 32'hFFFF_FFFF);
        chk("model MULT lo", m.r, 32'hFFFF_FFFE);
        m = model(4'd14, 32'hFFFF_FFF9, 32'd2, 5'd0);
`ifdef ALU_MDU_DIV_EN
        chk("model DIV q", m.r, 32'hFFFF_FFFD);
        chk("model DIV r", m.h, 32'hFFFF_FFFF);
`else
        chk("model DIV disabled", m.r, 32'd0);
`endif

        repeat (3) @(negedge clk);
        chk("reset in_ready", 32'(in_ready), 32'd1);
        resetn = 1'b1;

        do_op(4'd0, 32'h7FFF_FFFF, 32'd1, 5'd0, 0, lat);
        chk("ADD result", last_r, 32'h8000_0000);
        chk("ADD ovf", 32'(last_ovf), 32'd1);
        chk("ADD latency", 32'(lat), 32'd1);
        do_op(4'd1, 32'h7FFF_FFFF, 32'd1, 5'd0, 0, lat);
        chk("ADDU ovf", 32'(last_ovf), 32'd0);
        do_op(4'd12, 32'd0, 32'h8000_0000, 5'd4, 1, lat);
        chk("SRA result", last_r, 32'hF800_0000);
        do_op(4'd9, 32'd1, 32'hFFFF_FFFF, 5'd0, 0, lat);
        chk("SLTU result", last_r, 32'd1);
        do_op(4'd8, 32'd1, 32'hFFFF_FFFF, 5'd0, 0, lat);
        chk("SLT result", last_r, 32'd0);
        do_op(4'd13, 32'hFFFF_FFFF, 32'd2, 5'd0, 0, lat);
        chk("MULT hi", last_h, 32'hFFFF_FFFF);
        chk("MULT lo", last_r, 32'hFFFF_FFFE);
        do_op(4'd14, 32'hFFFF_FFF9, 32'd2, 5'd0, 0, lat);
`ifdef ALU_MDU_DIV_EN
        chk("DIV q", last_r, 32'hFFFF_FFFD);
        chk("DIV r", last_h, 32'hFFFF_FFFF);
        chk("DIV latency", 32'(lat), 32'd33);
`else
        chk("DIV disabled q", last_r, 32'd0);
        chk("DIV disabled latency", 32'(lat), 32'd1);
`endif
        do_op(4'd15, 32'd5, 32'd0, 5'd0, 0, lat);
`ifdef ALU_MDU_DIV_EN
        chk("DIVU/0 q", last_r, 32'hFFFF_FFFF);
        chk("DIVU/0 r", last_h, 32'd5);
        chk("DIVU/0 divzero", 32'(last_dz), 32'd1);
`else
        chk("DIVU disabled divzero", 32'(last_dz), 32'd0);
`endif
        do_op(4'd14, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 0, lat);
        do_op(4'd4, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd0, 5, lat);
        chk("AND result", last_r, 32'h00F0_1234);
        chk("IDLE after handshake", 32'(in_ready), 32'd1);

        // Reset in the middle of a division, then an ADD on the first edge after release.
        @(negedge clk);
        in_valid = 1'b1; op = 4'd14; num1 = 32'd1000; num2 = 32'd7; sa = '0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        chk("async reset out_valid", 32'(out_valid), 32'd0);
        chk("async reset result", result, 32'd0);
        chk("async reset hi", hi, 32'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        in_valid = 1'b1; op = 4'd0; num1 = 32'd2; num2 = 32'd3;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("post-reset ADD valid", 32'(out_valid), 32'd1);
        chk("post-reset ADD result", result, 32'd5);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        for (int i = 0; i < 200; i++) begin
            do_op(4'($urandom), pick(), pick(), 5'($urandom), $urandom_range(0, 3), lat);
        end

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
